// File: rtl/seq_pkg.sv
// Shared types and default widths for the sequence-generator burst controller.
package seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0]  count;
        logic [DATA_W_DEF-1:0] last;
        logic                  hit;
    } rsp_t;

endpackage

// File: rtl/seq_burst_ctrl.sv
// Burst controller: loads the external generator, steps it until length, stop
// pattern or abort, then offers the outcome as a valid/ready response.
module seq_burst_ctrl
    import seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_seed,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic              cmd_stop_en,
    input  logic [DATA_W-1:0] cmd_stop_pat,
    input  logic              abort,
    output logic              gen_load,
    output logic [DATA_W-1:0] gen_seed,
    output logic              gen_step,
    input  logic [DATA_W-1:0] gen_q,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CNT_W-1:0]  rsp_count,
    output logic [DATA_W-1:0] rsp_last,
    output logic              rsp_hit,
    output logic              busy
);

    state_t            state;
    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] pat_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              stop_en_q;
    rsp_t              rsp_q;
    logic              match;

    assign match     = stop_en_q && (gen_q == pat_q);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign gen_load  = (state == LOAD);
    assign rsp_valid = (state == RESP);
    assign gen_seed  = seed_q;
    assign rsp_count = rsp_q.count;
    assign rsp_last  = rsp_q.last;
    assign rsp_hit   = rsp_q.hit;

    // The only input-to-output path: a step is withheld in the very cycle
    // abort, a pattern match or the length limit is seen.
    always_comb begin
        gen_step = (state == RUN) && !abort && !match && (cnt_q != len_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            seed_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            stop_en_q <= 1'b0;
            rsp_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        seed_q    <= cmd_seed;
                        len_q     <= cmd_len;
                        stop_en_q <= cmd_stop_en;
                        pat_q     <= cmd_stop_pat;
                        cnt_q     <= '0;
                        if (cmd_len == '0) begin
                            rsp_q <= '{count: '0, last: gen_q, hit: 1'b0};
                            state <= RESP;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        rsp_q <= '{count: '0, last: gen_q, hit: 1'b0};
                        state <= RESP;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        rsp_q <= '{count: cnt_q, last: gen_q, hit: 1'b0};
                        state <= RESP;
                    end else if (match) begin
                        rsp_q <= '{count: cnt_q, last: gen_q, hit: 1'b1};
                        state <= RESP;
                    end else if (cnt_q == len_q) begin
                        rsp_q <= '{count: cnt_q, last: gen_q, hit: 1'b0};
                        state <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_burst_ctrl.sv
// Randomized bench for seq_burst_ctrl against a transaction-level burst model
// plus a rotate-left generator model standing in for the external generator.
module tb_seq_burst_ctrl;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_seed;
    logic [7:0] cmd_len;
    logic       cmd_stop_en;
    logic [7:0] cmd_stop_pat;
    logic       abort;
    logic       gen_load;
    logic [7:0] gen_seed;
    logic       gen_step;
    logic [7:0] gen_q;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_count;
    logic [7:0] rsp_last;
    logic       rsp_hit;
    logic       busy;

    seq_burst_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seed(cmd_seed),
        .cmd_len(cmd_len), .cmd_stop_en(cmd_stop_en), .cmd_stop_pat(cmd_stop_pat),
        .abort(abort), .gen_load(gen_load), .gen_seed(gen_seed), .gen_step(gen_step),
        .gen_q(gen_q), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_count(rsp_count), .rsp_last(rsp_last), .rsp_hit(rsp_hit), .busy(busy)
    );

    always #5 clk = ~clk;

    // External generator: load wins, step rotates left by one.
    logic [7:0] gq = 8'h3C;
    always @(posedge clk) begin
        if (gen_load)      gq <= gen_seed;
        else if (gen_step) gq <= {gq[6:0], gq[7]};
    end
    assign gen_q = gq;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] v;
        v = x;
        repeat (n) v = {v[6:0], v[7]};
        return v;
    endfunction

    // Expected outcome of one burst, derived from the command alone.
    // ab is the cycle offset (from acceptance) at which abort is raised, -1 for none.
    int         m_k, m_roff;
    bit         m_hit, m_ld;
    logic [7:0] m_last;

    function automatic void model(input logic [7:0] s, input int len, input bit en,
                                  input logic [7:0] pat, input int ab, input logic [7:0] qb);
        bit done;
        logic [7:0] v;
        done = 0;
        if (len == 0) begin
            m_k = 0; m_hit = 0; m_last = qb; m_roff = 1; m_ld = 0;
        end else if (ab == 1) begin
            m_k = 0; m_hit = 0; m_last = qb; m_roff = 2; m_ld = 1;
        end else begin
            m_ld = 1;
            for (int k = 0; k <= len && !done; k++) begin
                v = rotl(s, k);
                if (ab == 2 + k || (en && v == pat) || k == len) begin
                    done   = 1;
                    m_k    = k;
                    m_hit  = (ab != 2 + k) && en && (v == pat);
                    m_last = v;
                    m_roff = 3 + k;
                end
            end
        end
    endfunction

    bit         chk_en = 0;
    bit         act = 0;
    int         a_cyc, h_off;
    logic [7:0] cur_seed;
    int         first_rv, n_ld, n_st;
    logic [7:0] cap_cnt, cap_last;
    logic       cap_hit;
    int         off;

    always @(negedge clk) begin
        if (chk_en) begin
            if (act) begin
                off = cyc - a_cyc;
                chk("cmd_ready", cmd_ready, off == 0);
                chk("busy", busy, off != 0);
                chk("gen_load", gen_load, m_ld && off == 1);
                chk("gen_step", gen_step, m_ld && off >= 2 && (off - 2) < m_k);
                chk("rsp_valid", rsp_valid, off >= m_roff);
                if (off >= 1) chk("gen_seed", gen_seed, cur_seed);
                if (off >= m_roff) begin
                    chk("rsp_count", rsp_count, m_k);
                    chk("rsp_last", rsp_last, m_last);
                    chk("rsp_hit", rsp_hit, m_hit);
                end
                if (gen_load) n_ld++;
                if (gen_step) n_st++;
                if (rsp_valid && first_rv < 0) first_rv = off;
                if (off == h_off) begin
                    cap_cnt = rsp_count; cap_last = rsp_last; cap_hit = rsp_hit;
                end
            end else begin
                chk("idle_cmd_ready", cmd_ready, 1);
                chk("idle_busy", busy, 0);
                chk("idle_gen_load", gen_load, 0);
                chk("idle_gen_step", gen_step, 0);
                chk("idle_rsp_valid", rsp_valid, 0);
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns one cycle
    // after the response handshake.
    task automatic run_txn(input logic [7:0] s, input int len, input bit en,
                           input logic [7:0] pat, input int ab, input int rdly);
        model(s, len, en, pat, ab, gq);
        a_cyc = cyc; h_off = 100000; cur_seed = s;
        first_rv = -1; n_ld = 0; n_st = 0;
        act = 1;
        for (int o = 0; o < 400; o++) begin
            if (o == 0) begin
                cmd_valid = 1; cmd_seed = s; cmd_len = 8'(len);
                cmd_stop_en = en; cmd_stop_pat = pat;
            end else begin
                // commands offered while busy must be ignored
                cmd_valid = 1; cmd_seed = 8'($urandom); cmd_len = 8'($urandom);
                cmd_stop_en = 1'($urandom); cmd_stop_pat = 8'($urandom);
            end
            abort = (o == ab) || (o >= m_roff && $urandom_range(0, 2) == 0);
            if (o >= m_roff) rsp_ready = (o - m_roff >= rdly);
            else             rsp_ready = 1'($urandom);
            if (o >= m_roff && rsp_ready) h_off = o;
            @(posedge clk); #1;
            if (h_off == o) break;
        end
        if (h_off == 100000) begin
            n_fail++;
            $display("FAIL handshake_timeout: no handshake within budget (cycle %0d)", cyc);
        end
        cmd_valid = 0; abort = 0; rsp_ready = 0;
        act = 0;
    endtask

    initial begin
        reset = 1; cmd_valid = 1; cmd_seed = 8'h77; cmd_len = 8'd4;
        cmd_stop_en = 0; cmd_stop_pat = 8'h00; abort = 0; rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0; cmd_valid = 0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_gen_load", gen_load, 0);
        chk("rst_gen_step", gen_step, 0);
        chk("rst_gen_seed", gen_seed, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_count", rsp_count, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk_en = 1;

        // Full-length burst
        run_txn(8'h01, 3, 0, 8'h00, -1, 0);
        chk("t1_count", cap_cnt, 3);   chk("t1_last", cap_last, 8'h08);
        chk("t1_hit", cap_hit, 0);     chk("t1_rv_cycle", first_rv, 6);
        chk("t1_loads", n_ld, 1);      chk("t1_steps", n_st, 3);
        // Stop-pattern hit after two steps
        run_txn(8'h01, 10, 1, 8'h04, -1, 1);
        chk("t2_count", cap_cnt, 2);   chk("t2_last", cap_last, 8'h04);
        chk("t2_hit", cap_hit, 1);     chk("t2_steps", n_st, 2);
        // Seed already matches
        run_txn(8'hA5, 5, 1, 8'hA5, -1, 0);
        chk("t3_count", cap_cnt, 0);   chk("t3_last", cap_last, 8'hA5);
        chk("t3_hit", cap_hit, 1);     chk("t3_steps", n_st, 0);
        // Zero-length command
        run_txn(8'h5A, 0, 0, 8'h00, -1, 0);
        chk("t4_count", cap_cnt, 0);   chk("t4_rv_cycle", first_rv, 1);
        chk("t4_loads", n_ld, 0);      chk("t4_steps", n_st, 0);
        // Abort in third RUN cycle, response held for four cycles
        run_txn(8'h01, 10, 0, 8'h00, 4, 4);
        chk("t5_count", cap_cnt, 2);   chk("t5_last", cap_last, 8'h04);
        chk("t5_hit", cap_hit, 0);     chk("t5_steps", n_st, 2);
        // Longest burst: count reaches 255 without wrapping
        run_txn(8'h81, 255, 0, 8'h00, -1, 1);
        chk("t6_count", cap_cnt, 255); chk("t6_steps", n_st, 255);

        for (int t = 0; t < 150; t++) begin
            logic [7:0] s, pat;
            int len, ab;
            bit en;
            s   = 8'($urandom);
            len = $urandom_range(0, 12);
            en  = 1'($urandom);
            pat = ($urandom_range(0, 1) == 1) ? rotl(s, $urandom_range(0, 14)) : 8'($urandom);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len + 4) : -1;
            run_txn(s, len, en, pat, ab, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of RUN with a command pending
        chk_en = 0;
        cmd_valid = 1; cmd_seed = 8'h01; cmd_len = 8'd10; cmd_stop_en = 0;
        @(posedge clk); #1;
        cmd_valid = 0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_step", gen_step, 1);
        reset = 1; cmd_valid = 1; rsp_ready = 1;
        @(posedge clk); #1;
        reset = 0; cmd_valid = 0;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gen_step", gen_step, 0);
        chk("mid_rst_gen_load", gen_load, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_count", rsp_count, 0);
        chk("mid_rst_rsp_last", rsp_last, 0);
        chk("mid_rst_gen_seed", gen_seed, 0);
        repeat (15) begin
            @(posedge clk); #1;
            chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        rsp_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
